vx_dcache_responder: RTL and testbench

//  Responder end of the dcache core request/response interface: multi-lane local word memory.

---
 rtl/vx_dcache_responder.sv | 204 ++++++++++++++++++++
 tb/tb_vx_dcache_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vx_dcache_responder.sv
// vx_dcache_responder: responder end of the dcache core request/response
// interface, backed by a multi-lane local word memory on a single-port
// synchronous SRAM. One batch of per-lane requests is captured, the lanes are
// served one per cycle in ascending lane order, and a single response beat
// returns every read lane of the batch under the batch tag.
//
// Optional feature: define VX_DRSP_COALESCE_EN to let read-only batches reuse
// the data of a lower lane with the same word address, without spending a
// SERVE cycle on it. Response contents are identical either way.
module vx_dcache_responder #(
  parameter int NUM_LANES  = 4,
  parameter int SIZE_WORDS = 1024,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LANES-1:0]           core_req_valid,
  input  logic [NUM_LANES-1:0]           core_req_rw,
  input  logic [NUM_LANES*30-1:0]        core_req_addr,
  input  logic [NUM_LANES*4-1:0]         core_req_byteen,
  input  logic [NUM_LANES*32-1:0]        core_req_data,
  input  logic [NUM_LANES*TAG_WIDTH-1:0] core_req_tag,
  output logic [NUM_LANES-1:0]           core_req_ready,
  output logic [NUM_LANES-1:0]           core_rsp_valid,
  output logic [NUM_LANES*32-1:0]        core_rsp_data,
  output logic [TAG_WIDTH-1:0]           core_rsp_tag,
  input  logic                           core_rsp_ready
);

  localparam int ADDR_BITS = $clog2(SIZE_WORDS);
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int HI_BITS   = 30 - ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE,
    ST_RESP
  } state_t;

  state_t state, state_next;

  // Captured batch
  logic [NUM_LANES-1:0] b_rw;
  logic [NUM_LANES-1:0] pend;     // lanes still waiting for their SRAM cycle
  logic [NUM_LANES-1:0] rd_mask;  // read lanes reported in the response
  logic [ADDR_BITS-1:0] b_addr   [NUM_LANES];
  logic [3:0]           b_byteen [NUM_LANES];
  logic [31:0]          b_data   [NUM_LANES];
  logic [LANE_W-1:0]    b_src    [NUM_LANES];  // lane whose read data this lane returns
  logic [TAG_WIDTH-1:0] b_tag;

  // Read return path
  logic [31:0]          rd_data [NUM_LANES];
  logic                 rd_pend;
  logic [LANE_W-1:0]    rd_lane;
  logic                 armed;    // RESP entered one cycle ago: last read has landed

  // Storage
  logic [31:0]          mem [SIZE_WORDS];
  logic [31:0]          sram_q;

  // Request decode
  logic [ADDR_BITS-1:0] req_addr [NUM_LANES];
  logic [TAG_WIDTH-1:0] req_tag;
  logic [LANE_W-1:0]    req_src  [NUM_LANES];
  logic [NUM_LANES-1:0] req_dup;
  logic [NUM_LANES*HI_BITS-1:0] unused_addr_hi;

  // Lane scheduling
  logic [LANE_W-1:0]    cur_lane;
  logic [NUM_LANES-1:0] cur_onehot;
  logic                 serve_wr;
  logic                 serve_rd;
  logic                 serve_last;

  // Slice the decoded word address per lane and pick the tag of the lowest valid lane.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req_tag        = '0;
    unused_addr_hi = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (core_req_valid[l]) req_tag = core_req_tag[l*TAG_WIDTH +: TAG_WIDTH];
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      req_addr[l] = core_req_addr[l*30 +: ADDR_BITS];
      unused_addr_hi[l*HI_BITS +: HI_BITS] = core_req_addr[l*30+ADDR_BITS +: HI_BITS];
    end
  end

  // Map duplicate-address lanes of a read-only batch onto the lowest matching lane.
  always_comb begin
    req_dup = '0;
    for (int l = 0; l < NUM_LANES; l++) req_src[l] = LANE_W'(l);
`ifdef VX_DRSP_COALESCE_EN
    if ((core_req_valid & core_req_rw) == '0) begin
      for (int j = 1; j < NUM_LANES; j++) begin
        for (int i = j - 1; i >= 0; i--) begin
          if (core_req_valid[j] && core_req_valid[i] && (req_addr[i] == req_addr[j])) begin
            req_dup[j] = 1'b1;
            req_src[j] = LANE_W'(i);
          end
        end
      end
    end
`endif
  end

  // Select the lowest pending lane for this SERVE cycle.
  always_comb begin
    cur_lane   = '0;
    cur_onehot = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (pend[l]) begin
        cur_lane   = LANE_W'(l);
        cur_onehot = '0;
        cur_onehot[l] = 1'b1;
      end
    end
    serve_wr   = (state == ST_SERVE) &&  b_rw[cur_lane];
    serve_rd   = (state == ST_SERVE) && !b_rw[cur_lane];
    serve_last = (pend & ~cur_onehot) == '0;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (core_req_valid != '0) state_next = ST_SERVE;
      ST_SERVE: if (serve_last) state_next = (rd_mask != '0) ? ST_RESP : ST_IDLE;
      ST_RESP:  if (armed && core_rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Single-port SRAM: byte-masked write or registered read, one lane per cycle.
  // NOTE: storage is deliberately not reset; only control state is.
  always_ff @(posedge clk) begin
    if (serve_wr && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (b_byteen[cur_lane][b]) mem[b_addr[cur_lane]][b*8 +: 8] <= b_data[cur_lane][b*8 +: 8];
      end
    end
    if (serve_rd) sram_q <= mem[b_addr[cur_lane]];
  end

  // Batch capture, lane retirement and read-data return.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_rw    <= '0;
      pend    <= '0;
      rd_mask <= '0;
      b_tag   <= '0;
      rd_pend <= 1'b0;
      rd_lane <= '0;
      armed   <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        b_addr[l]   <= '0;
        b_byteen[l] <= '0;
        b_data[l]   <= '0;
        b_src[l]    <= '0;
        rd_data[l]  <= '0;
      end
    end else begin
      armed   <= (state == ST_RESP) && (state_next == ST_RESP);
      rd_pend <= serve_rd;
      rd_lane <= cur_lane;
      if (rd_pend) rd_data[rd_lane] <= sram_q;
      case (state)
        ST_IDLE: begin
          if (core_req_valid != '0) begin
            pend    <= core_req_valid & ~req_dup;
            rd_mask <= core_req_valid & ~core_req_rw;
            b_rw    <= core_req_rw;
            b_tag   <= req_tag;
            for (int l = 0; l < NUM_LANES; l++) begin
              b_addr[l]   <= req_addr[l];
              b_byteen[l] <= core_req_byteen[l*4 +: 4];
              b_data[l]   <= core_req_data[l*32 +: 32];
              b_src[l]    <= req_src[l];
            end
          end
        end
        ST_SERVE: pend <= pend & ~cur_onehot;
        default: ;
      endcase
    end
  end

  // Handshake outputs and per-lane response data (coalesced lanes read their source slot).
  always_comb begin
    core_req_ready = ((state == ST_IDLE) && !reset) ? '1 : '0;
    core_rsp_valid = ((state == ST_RESP) && armed) ? rd_mask : '0;
    core_rsp_tag   = b_tag;
    core_rsp_data  = '0;
    for (int l = 0; l < NUM_LANES; l++) core_rsp_data[l*32 +: 32] = rd_data[b_src[l]];
  end

endmodule

// File: tb/tb_vx_dcache_responder.sv
// Directed testbench for vx_dcache_responder (NUM_LANES=4, SIZE_WORDS=1024, TAG_WIDTH=8).
module tb_vx_dcache_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   core_req_valid;
  logic [3:0]   core_req_rw;
  logic [119:0] core_req_addr;
  logic [15:0]  core_req_byteen;
  logic [127:0] core_req_data;
  logic [31:0]  core_req_tag;
  logic [3:0]   core_req_ready;
  logic [3:0]   core_rsp_valid;
  logic [127:0] core_rsp_data;
  logic [7:0]   core_rsp_tag;
  logic         core_rsp_ready;

  int total = 0;
  int bad   = 0;
  int cyc;
  logic flag;

`ifdef VX_DRSP_COALESCE_EN
  localparam int T5_CYC = 3;
`else
  localparam int T5_CYC = 6;
`endif

  localparam logic [127:0] DATA_A = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};

  vx_dcache_responder #(.NUM_LANES(4), .SIZE_WORDS(1024), .TAG_WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .core_req_valid (core_req_valid),
    .core_req_rw    (core_req_rw),
    .core_req_addr  (core_req_addr),
    .core_req_byteen(core_req_byteen),
    .core_req_data  (core_req_data),
    .core_req_tag   (core_req_tag),
    .core_req_ready (core_req_ready),
    .core_rsp_valid (core_rsp_valid),
    .core_rsp_data  (core_rsp_data),
    .core_rsp_tag   (core_rsp_tag),
    .core_rsp_ready (core_rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [127:0] lane_mask(input logic [3:0] m);
    return {{32{m[3]}}, {32{m[2]}}, {32{m[1]}}, {32{m[0]}}};
  endfunction

  // Drive one batch at a negedge in IDLE; returns just after the capture edge (cycle 1).
  task automatic send(input logic [3:0] v, input logic [3:0] rw,
                      input logic [29:0] a0, input logic [29:0] a1,
                      input logic [29:0] a2, input logic [29:0] a3,
                      input logic [15:0] be, input logic [127:0] d, input logic [31:0] tg);
    check("send_ready", core_req_ready, 4'hF);
    core_req_valid  = v;
    core_req_rw     = rw;
    core_req_addr   = {a3, a2, a1, a0};
    core_req_byteen = be;
    core_req_data   = d;
    core_req_tag    = tg;
    @(posedge clk);
    #1;
    core_req_valid = 4'h0;
  endtask

  // Count cycles after capture until the response beat shows; flag any ready while busy.
  task automatic wait_rsp(output int c_out, output logic busy_ready);
    c_out = -1;
    busy_ready = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (core_rsp_valid !== 4'h0) begin
        c_out = c;
        break;
      end
      if (core_req_ready !== 4'h0) busy_ready = 1'b1;
    end
  endtask

  // For write-only batches: cycle at which ready returns; flag any response beat.
  task automatic wait_idle(output int c_out, output logic saw_rsp);
    c_out = -1;
    saw_rsp = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (core_rsp_valid !== 4'h0) saw_rsp = 1'b1;
      if (core_req_ready === 4'hF) begin
        c_out = c;
        break;
      end
    end
  endtask

  task automatic check_rsp(input string name, input logic [3:0] v,
                           input logic [127:0] d, input logic [7:0] tg);
    check({name, "_valid"}, core_rsp_valid, v);
    check({name, "_data"}, core_rsp_data & lane_mask(v), d & lane_mask(v));
    check({name, "_tag"}, core_rsp_tag, tg);
  endtask

  // One cycle after an accepted beat: response gone, block idle again.
  task automatic finish_rsp(input string name);
    @(negedge clk);
    check({name, "_rsp_done"}, core_rsp_valid, 4'h0);
    check({name, "_idle_ready"}, core_req_ready, 4'hF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    core_req_valid = '0; core_req_rw = '0; core_req_addr = '0;
    core_req_byteen = '0; core_req_data = '0; core_req_tag = '0;
    core_rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_ready", core_req_ready, 4'h0);
    check("reset_rsp_valid", core_rsp_valid, 4'h0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", core_req_ready, 4'hF);

    // 1. Four-lane write, then read back under tag 0x15.
    send(4'hF, 4'hF, 30'd0, 30'd1, 30'd2, 30'd3, 16'hFFFF, DATA_A, {4{8'h01}});
    wait_idle(cyc, flag);
    check("t1_wr_idle_cycle", cyc, 5);
    check("t1_wr_no_rsp", flag, 1'b0);
    send(4'hF, 4'h0, 30'd0, 30'd1, 30'd2, 30'd3, 16'h0, 128'h0, {4{8'h15}});
    wait_rsp(cyc, flag);
    check("t1_rsp_cycle", cyc, 6);
    check("t1_busy_ready", flag, 1'b0);
    check_rsp("t1", 4'hF, DATA_A, 8'h15);
    finish_rsp("t1");

    // 2. Byte enables on word 8.
    send(4'h1, 4'h1, 30'd8, 30'd0, 30'd0, 30'd0, 16'h000F, 128'hFFFFFFFF, {4{8'h02}});
    wait_idle(cyc, flag);
    check("t2_wr1_idle_cycle", cyc, 2);
    send(4'h1, 4'h1, 30'd8, 30'd0, 30'd0, 30'd0, 16'h0005, 128'h0, {4{8'h02}});
    wait_idle(cyc, flag);
    check("t2_wr2_idle_cycle", cyc, 2);
    send(4'h1, 4'h0, 30'd8, 30'd0, 30'd0, 30'd0, 16'h0, 128'h0, {4{8'h03}});
    wait_rsp(cyc, flag);
    check("t2_rsp_cycle", cyc, 3);
    check_rsp("t2", 4'h1, 128'hFF00FF00, 8'h03);
    finish_rsp("t2");

    // 3. Partial batch, then resubmit the remaining lanes under the same tag.
    send(4'h5, 4'h0, 30'd0, 30'd1, 30'd2, 30'd3, 16'h0, 128'h0, {8'hEE, 8'h22, 8'hEE, 8'h22});
    wait_rsp(cyc, flag);
    check("t3a_rsp_cycle", cyc, 4);
    check("t3a_busy_ready", flag, 1'b0);
    check_rsp("t3a", 4'h5, DATA_A, 8'h22);
    finish_rsp("t3a");
    send(4'hA, 4'h0, 30'd0, 30'd1, 30'd2, 30'd3, 16'h0, 128'h0, {8'h22, 8'hEE, 8'h22, 8'hEE});
    wait_rsp(cyc, flag);
    check("t3b_rsp_cycle", cyc, 4);
    check_rsp("t3b", 4'hA, DATA_A, 8'h22);
    finish_rsp("t3b");

    // 4. Mixed batch with read-after-write, response held back for 5 cycles.
    core_rsp_ready = 1'b0;
    send(4'hF, 4'h9, 30'd20, 30'd20, 30'd1, 30'd21, 16'hFFFF,
         {32'hDEADBEEF, 32'h0, 32'h0, 32'h12345678}, {4{8'h4C}});
    wait_rsp(cyc, flag);
    check("t4_rsp_cycle", cyc, 6);
    check_rsp("t4_first", 4'h6, {32'h0, 32'hA1A1A1A1, 32'h12345678, 32'h0}, 8'h4C);
    repeat (5) begin
      @(negedge clk);
      check_rsp("t4_hold", 4'h6, {32'h0, 32'hA1A1A1A1, 32'h12345678, 32'h0}, 8'h4C);
      check("t4_hold_ready", core_req_ready, 4'h0);
    end
    core_rsp_ready = 1'b1;
    finish_rsp("t4");

    // 5. Four reads of the same word.
    send(4'h1, 4'h1, 30'd7, 30'd0, 30'd0, 30'd0, 16'h000F, 128'h0BADF00D, {4{8'h04}});
    wait_idle(cyc, flag);
    check("t5_wr_idle_cycle", cyc, 2);
    send(4'hF, 4'h0, 30'd7, 30'd7, 30'd7, 30'd7, 16'h0, 128'h0, {4{8'h33}});
    wait_rsp(cyc, flag);
    check("t5_rsp_cycle", cyc, T5_CYC);
    check_rsp("t5", 4'hF, {4{32'h0BADF00D}}, 8'h33);
    finish_rsp("t5");

    // Address wrap: 1024+5 aliases word 5, 1024 aliases word 0.
    send(4'h1, 4'h1, 30'h405, 30'd0, 30'd0, 30'd0, 16'h000F, 128'h55AA55AA, {4{8'h05}});
    wait_idle(cyc, flag);
    check("alias_wr_idle_cycle", cyc, 2);
    send(4'h3, 4'h0, 30'd5, 30'h400, 30'd0, 30'd0, 16'h0, 128'h0, {4{8'h5A}});
    wait_rsp(cyc, flag);
    check("alias_rsp_cycle", cyc, 4);
    check_rsp("alias", 4'h3, {64'h0, 32'hA0A0A0A0, 32'h55AA55AA}, 8'h5A);
    finish_rsp("alias");

    // 6. Reset in the middle of SERVE drops the batch; storage survives.
    send(4'hF, 4'h0, 30'd0, 30'd1, 30'd2, 30'd3, 16'h0, 128'h0, {4{8'h66}});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_reset_ready", core_req_ready, 4'h0);
    check("t6_reset_rsp_valid", core_rsp_valid, 4'h0);
    reset = 1'b0;
    @(negedge clk);
    check("t6_post_reset_ready", core_req_ready, 4'hF);
    flag = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (core_rsp_valid !== 4'h0 || core_req_ready !== 4'hF) flag = 1'b1;
    end
    check("t6_no_rsp_after_reset", flag, 1'b0);
    send(4'hF, 4'h0, 30'd0, 30'd1, 30'd2, 30'd3, 16'h0, 128'h0, {4{8'h77}});
    wait_rsp(cyc, flag);
    check("t6_rsp_cycle", cyc, 6);
    check_rsp("t6", 4'hF, DATA_A, 8'h77);
    finish_rsp("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
